// File: rtl/ethernet_rx_buffer.sv
// ethernet_rx_buffer
//   Receive-side frame buffer. Assembles payload dibits into bytes and stores
//   them as {last, byte} entries in a circular memory. Bytes become visible on
//   the output only after the whole frame is committed by rx_done. Frames
//   ended by rx_kill, or frames that do not fit, are rolled back and counted
//   as dropped.
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   axiid[1:0]  : payload dibit, MSB-first within each byte
//   axiiv       : axiid valid
//   rx_done     : frame-end pulse (CRC evaluated)
//   rx_kill     : frame-abort pulse (CRC failed / aborted)
//   axiod[7:0]  : committed byte at the head of the buffer (fall-through)
//   axiov       : axiod valid
//   axiol       : axiod is the last byte of its frame
//   axiir       : downstream ready
//   frame_count : committed frames, wraps
//   drop_count  : dropped frames, saturates at 255
module ethernet_rx_buffer #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] axiid,
    input  logic       axiiv,
    input  logic       rx_done,
    input  logic       rx_kill,
    output logic [7:0] axiod,
    output logic       axiov,
    output logic       axiol,
    input  logic       axiir,
    output logic [7:0] frame_count,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RECV, OVERFLOW} state_t;

    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [1:0]    r_dcnt;
    logic [5:0]    r_shift;
    logic [7:0]    r_hold;
    logic          r_hold_v;
    logic [7:0]    r_frame_count;
    logic [7:0]    r_drop_count;
    logic [8:0]    r_mem [DEPTH];

    state_t        w_state_nx;
    logic [PW-1:0] w_wr_ptr_nx;
    logic [PW-1:0] w_commit_nx;
    logic [1:0]    w_dcnt_nx;
    logic [5:0]    w_shift_nx;
    logic [7:0]    w_hold_nx;
    logic          w_hold_v_nx;
    logic [7:0]    w_frame_nx;
    logic [7:0]    w_drop_nx;
    logic          w_wr_en;
    logic [8:0]    w_wr_data;
    logic          w_go_idle;
    logic          w_drop_frame;
    logic          w_full;
    logic [7:0]    w_byte;
    logic          w_axiov;
    logic [8:0]    w_head;

    assign w_full  = ((r_wr_ptr - r_rd_ptr) == PW'(DEPTH));
    assign w_byte  = {r_shift, axiid};
    assign w_axiov = (r_rd_ptr != r_commit_ptr);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Gated so the outputs read zero whenever nothing is committed (incl. reset).
    assign axiov       = w_axiov;
    assign axiod       = w_axiov ? w_head[7:0] : 8'h00;
    assign axiol       = w_axiov ? w_head[8]   : 1'b0;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;

    always_comb begin
        w_state_nx   = r_state;
        w_wr_ptr_nx  = r_wr_ptr;
        w_commit_nx  = r_commit_ptr;
        w_dcnt_nx    = r_dcnt;
        w_shift_nx   = r_shift;
        w_hold_nx    = r_hold;
        w_hold_v_nx  = r_hold_v;
        w_frame_nx   = r_frame_count;
        w_drop_nx    = r_drop_count;
        w_wr_en      = 1'b0;
        w_wr_data    = '0;
        w_go_idle    = 1'b0;
        w_drop_frame = 1'b0;

        case (r_state)
            IDLE: begin
                if (axiiv) begin
                    w_state_nx = RECV;
                    w_shift_nx = {r_shift[3:0], axiid};
                    w_dcnt_nx  = 2'd1;
                end
            end
            RECV: begin
                if (rx_kill) begin
                    w_drop_frame = 1'b1;
                end else if (rx_done) begin
                    if (!r_hold_v) begin
                        w_go_idle = 1'b1;
                    end else if (w_full) begin
                        w_drop_frame = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = {1'b1, r_hold};
                        w_wr_ptr_nx = r_wr_ptr + PW'(1);
                        w_commit_nx = r_wr_ptr + PW'(1);
                        w_frame_nx  = r_frame_count + 8'd1;
                        w_go_idle   = 1'b1;
                    end
                end else if (axiiv) begin
                    w_dcnt_nx = r_dcnt + 2'd1;
                    if (r_dcnt == 2'd3) begin
                        // Byte complete: the previously held byte is now known
                        // not to be the last one, so it can go to memory.
                        w_shift_nx = '0;
                        if (r_hold_v) begin
                            if (w_full) begin
                                w_state_nx = OVERFLOW;
                            end else begin
                                w_wr_en     = 1'b1;
                                w_wr_data   = {1'b0, r_hold};
                                w_wr_ptr_nx = r_wr_ptr + PW'(1);
                                w_hold_nx   = w_byte;
                            end
                        end else begin
                            w_hold_nx   = w_byte;
                            w_hold_v_nx = 1'b1;
                        end
                    end else begin
                        w_shift_nx = {r_shift[3:0], axiid};
                    end
                end
            end
            OVERFLOW: begin
                if (rx_kill || rx_done) begin
                    w_drop_frame = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (w_drop_frame) begin
            w_wr_ptr_nx = r_commit_ptr;
            w_drop_nx   = (r_drop_count == 8'hFF) ? r_drop_count : r_drop_count + 8'd1;
            w_go_idle   = 1'b1;
        end

        // Any return to IDLE discards partial-byte dibits and the held byte.
        if (w_go_idle) begin
            w_state_nx  = IDLE;
            w_dcnt_nx   = '0;
            w_shift_nx  = '0;
            w_hold_nx   = '0;
            w_hold_v_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_dcnt        <= '0;
            r_shift       <= '0;
            r_hold        <= '0;
            r_hold_v      <= 1'b0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_wr_ptr      <= w_wr_ptr_nx;
            r_commit_ptr  <= w_commit_nx;
            r_dcnt        <= w_dcnt_nx;
            r_shift       <= w_shift_nx;
            r_hold        <= w_hold_nx;
            r_hold_v      <= w_hold_v_nx;
            r_frame_count <= w_frame_nx;
            r_drop_count  <= w_drop_nx;
            if (w_axiov && axiir) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_ethernet_rx_buffer.sv
module tb_ethernet_rx_buffer;

    logic       clk;
    logic       rst;
    logic [1:0] axiid;
    logic       axiiv;
    logic       rx_done;
    logic       rx_kill;
    logic [7:0] axiod;
    logic       axiov;
    logic       axiol;
    logic       axiir;
    logic [7:0] frame_count;
    logic [7:0] drop_count;

    int total = 0;
    int bad   = 0;

    ethernet_rx_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
        .rx_done(rx_done), .rx_kill(rx_kill), .axiod(axiod), .axiov(axiov),
        .axiol(axiol), .axiir(axiir), .frame_count(frame_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            axiiv = 1'b1;
            axiid = b[7-2*i -: 2];
            tick();
        end
        axiiv = 1'b0;
    endtask

    task automatic send_dibit(input logic [1:0] d);
        axiiv = 1'b1; axiid = d; tick(); axiiv = 1'b0;
    endtask

    task automatic end_frame(input logic d, input logic k);
        rx_done = d; rx_kill = k; tick(); rx_done = 1'b0; rx_kill = 1'b0;
    endtask

    task automatic test_reset();
        axiir = 1'b0;
        send_dibit(2'b11);
        do_reset();
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL reset_axiov got=%0b exp=0", axiov); end
        total++; if (axiol !== 1'b0) begin bad++; $display("FAIL reset_axiol got=%0b exp=0", axiol); end
        total++; if (axiod !== 8'h00) begin bad++; $display("FAIL reset_axiod got=%h exp=00", axiod); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_frames got=%0d exp=0", frame_count); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
    endtask

    task automatic test_basic();
        do_reset(); axiir = 1'b1;
        send_byte(8'hA5);
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL basic_uncommitted1 got=%0b exp=0", axiov); end
        send_byte(8'h3C);
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL basic_uncommitted2 got=%0b exp=0", axiov); end
        end_frame(1'b1, 1'b0);
        total++; if (axiov !== 1'b1 || axiod !== 8'hA5 || axiol !== 1'b0) begin bad++;
            $display("FAIL basic_byte0 got=v%0b d%h l%0b exp=v1 dA5 l0", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b1 || axiod !== 8'h3C || axiol !== 1'b1) begin bad++;
            $display("FAIL basic_byte1 got=v%0b d%h l%0b exp=v1 d3C l1", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL basic_drained got=%0b exp=0", axiov); end
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL basic_frames got=%0d exp=1", frame_count); end
    endtask

    task automatic test_kill();
        for (int m = 0; m < 2; m++) begin
            do_reset(); axiir = 1'b1;
            send_byte(8'hA5); send_byte(8'h3C);
            end_frame(m == 1, 1'b1);
            tick();
            total++; if (axiov !== 1'b0) begin bad++; $display("FAIL kill%0d_axiov got=%0b exp=0", m, axiov); end
            total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL kill%0d_drops got=%0d exp=1", m, drop_count); end
            total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL kill%0d_frames got=%0d exp=0", m, frame_count); end
            // Rolled-back write pointer: the next frame must start at slot 0.
            send_byte(8'h77);
            end_frame(1'b1, 1'b0);
            total++; if (axiov !== 1'b1 || axiod !== 8'h77 || axiol !== 1'b1) begin bad++;
                $display("FAIL kill%0d_next got=v%0b d%h l%0b exp=v1 d77 l1", m, axiov, axiod, axiol); end
        end
    endtask

    task automatic test_overflow();
        do_reset(); axiir = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
        end_frame(1'b1, 1'b0);
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL ovf_axiov got=%0b exp=0", axiov); end
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drops got=%0d exp=1", drop_count); end
        send_byte(8'h12); send_byte(8'h34);
        end_frame(1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            total++; if (axiov !== 1'b1 || axiod !== 8'h12 || axiol !== 1'b0) begin bad++;
                $display("FAIL ovf_stall%0d got=v%0b d%h l%0b exp=v1 d12 l0", s, axiov, axiod, axiol); end
            tick();
        end
        axiir = 1'b1; tick();
        total++; if (axiov !== 1'b1 || axiod !== 8'h34 || axiol !== 1'b1) begin bad++;
            $display("FAIL ovf_byte1 got=v%0b d%h l%0b exp=v1 d34 l1", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b exp=0", axiov); end
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL ovf_frames got=%0d exp=1", frame_count); end
    endtask

    task automatic test_full_boundary();
        do_reset(); axiir = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        end_frame(1'b1, 1'b0);
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL full_frames got=%0d exp=1", frame_count); end
        // Buffer is now exactly full: the held byte of a 1-byte frame cannot be written.
        send_byte(8'hEE);
        end_frame(1'b1, 1'b0);
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL full_drops got=%0d exp=1", drop_count); end
        axiir = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (axiov !== 1'b1 || axiod !== 8'(i) || axiol !== (i == 4)) begin bad++;
                $display("FAIL full_byte%0d got=v%0b d%h l%0b exp=v1 d%h l%0b", i, axiov, axiod, axiol, 8'(i), (i == 4)); end
            tick();
        end
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL full_drained got=%0b exp=0", axiov); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed [4];
        logic       el [4];
        int idx;
        ed = '{8'h11, 8'h22, 8'h44, 8'h55};
        el = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(); axiir = 1'b0;
        send_byte(8'h11); send_byte(8'h22); end_frame(1'b1, 1'b0);
        send_byte(8'h44); send_byte(8'h55); end_frame(1'b1, 1'b0);
        total++; if (frame_count !== 8'd2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", frame_count); end
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            axiir = (c % 2 == 0);
            total++; if (axiov !== 1'b1 || axiod !== ed[idx] || axiol !== el[idx]) begin bad++;
                $display("FAIL b2b_cycle%0d got=v%0b d%h l%0b exp=v1 d%h l%0b", c, axiov, axiod, axiol, ed[idx], el[idx]); end
            if (axiir) idx++;
            tick();
        end
        axiir = 1'b0;
        total++; if (idx != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", idx); end
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b exp=0", axiov); end
    endtask

    task automatic test_midframe_reset();
        do_reset(); axiir = 1'b1;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        do_reset();
        send_byte(8'h5A);
        end_frame(1'b1, 1'b0);
        total++; if (axiov !== 1'b1 || axiod !== 8'h5A || axiol !== 1'b1) begin bad++;
            $display("FAIL mrst_byte got=v%0b d%h l%0b exp=v1 d5A l1", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL mrst_drained got=%0b exp=0", axiov); end
        total++; if (frame_count !== 8'd1 || drop_count !== 8'd0) begin bad++;
            $display("FAIL mrst_counts got=f%0d d%0d exp=f1 d0", frame_count, drop_count); end
    endtask

    task automatic test_partial();
        do_reset(); axiir = 1'b0;
        send_byte(8'hC3); send_byte(8'h96); send_dibit(2'b11);
        end_frame(1'b1, 1'b0);
        total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL part_frames got=%0d exp=1", frame_count); end
        // Frame-end pulses while idle must be ignored.
        end_frame(1'b1, 1'b0);
        end_frame(1'b0, 1'b1);
        total++; if (frame_count !== 8'd1 || drop_count !== 8'd0) begin bad++;
            $display("FAIL part_idle got=f%0d d%0d exp=f1 d0", frame_count, drop_count); end
        send_byte(8'h0F); end_frame(1'b1, 1'b0);
        axiir = 1'b1;
        total++; if (axiov !== 1'b1 || axiod !== 8'hC3 || axiol !== 1'b0) begin bad++;
            $display("FAIL part_byte0 got=v%0b d%h l%0b exp=v1 dC3 l0", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b1 || axiod !== 8'h96 || axiol !== 1'b1) begin bad++;
            $display("FAIL part_byte1 got=v%0b d%h l%0b exp=v1 d96 l1", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b1 || axiod !== 8'h0F || axiol !== 1'b1) begin bad++;
            $display("FAIL part_next got=v%0b d%h l%0b exp=v1 d0F l1", axiov, axiod, axiol); end
        tick();
        total++; if (axiov !== 1'b0) begin bad++; $display("FAIL part_drained got=%0b exp=0", axiov); end
    endtask

    task automatic test_counters();
        do_reset(); axiir = 1'b1;
        for (int i = 0; i < 255; i++) begin send_byte(8'h5A); end_frame(1'b1, 1'b0); end
        total++; if (frame_count !== 8'd255) begin bad++; $display("FAIL cnt_frames255 got=%0d exp=255", frame_count); end
        send_byte(8'h5A); end_frame(1'b1, 1'b0);
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL cnt_frames_wrap got=%0d exp=0", frame_count); end
        for (int i = 0; i < 255; i++) begin send_dibit(2'b01); end_frame(1'b0, 1'b1); end
        total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL cnt_drops255 got=%0d exp=255", drop_count); end
        for (int i = 0; i < 5; i++) begin send_dibit(2'b01); end_frame(1'b0, 1'b1); end
        total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL cnt_drops_sat got=%0d exp=255", drop_count); end
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL cnt_frames_after got=%0d exp=0", frame_count); end
    endtask

    initial begin
        rst = 1'b1; axiid = 2'b00; axiiv = 1'b0; rx_done = 1'b0; rx_kill = 1'b0; axiir = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_kill();
        test_overflow();
        test_full_boundary();
        test_back_to_back();
        test_midframe_reset();
        test_partial();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
